gate_response_checker: RTL

- Receive end of the two-input gate test flow.
- A stimulus source drives {a,b} vectors into a NAND/OR/XOR gate unit. This block samples each applied vector together with the unit's y1/y2/y3 response.
- It compares each response against the golden NAND/OR/XOR values, counts vectors and mismatches, and tracks input-combination coverage.
- At the end it reports a registered pass/fail verdict, so a bench or on-chip self-test can check the gate unit without printed output.

---
 rtl/gate_response_checker.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gate_response_checker.sv
// Receive-side checker for a NAND/OR/XOR gate unit: scores vectors, tracks {a,b} coverage, registers a verdict.
// Optional first-mismatch capture ports (fail_valid, fail_vec) are enabled by defining GATE_CHK_FIRST_FAIL_EN.
module gate_response_checker #(
    parameter int unsigned NUM_VECTORS = 4,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             chk_valid,
    input  logic             chk_a,
    input  logic             chk_b,
    input  logic             chk_y1,
    input  logic             chk_y2,
    input  logic             chk_y3,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       vec_count,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       coverage
`ifdef GATE_CHK_FIRST_FAIL_EN
    ,
    output logic             fail_valid,
    output logic [4:0]       fail_vec
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0]       LAST_VEC = 8'(NUM_VECTORS);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    logic [1:0]       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [7:0]       vec_count_q, vec_count_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [3:0]       coverage_q, coverage_d;

    logic [1:0] ab;
    logic [2:0] exp_y;
    logic [2:0] obs_y;
    logic       mismatch;
    logic       accept;
    logic       run_start;

    assign ab        = {chk_a, chk_b};
    assign exp_y     = {~(chk_a & chk_b), chk_a | chk_b, chk_a ^ chk_b};
    assign obs_y     = {chk_y1, chk_y2, chk_y3};
    assign mismatch  = (obs_y != exp_y);
    assign accept    = (state_q == ST_RUN) && chk_valid;
    assign run_start = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;

    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        vec_count_d = vec_count_q;
        err_count_d = err_count_q;
        coverage_d  = coverage_q;

        if (run_start) begin
            state_d     = ST_RUN;
            pass_d      = 1'b0;
            vec_count_d = '0;
            err_count_d = '0;
            coverage_d  = '0;
        end else if (accept) begin
            vec_count_d = vec_count_q + 8'd1;
            coverage_d  = coverage_q | (4'b0001 << ab);
            if (mismatch && (err_count_q != ERR_MAX)) begin
                err_count_d = err_count_q + ERR_W'(1);
            end
            // Verdict is computed from the post-accept values so it is valid with done.
            if (vec_count_d == LAST_VEC) begin
                state_d = ST_DONE;
                pass_d  = (err_count_d == '0) && (coverage_d == 4'hF);
            end
        end else if ((state_q != ST_IDLE) && (state_q != ST_RUN) && (state_q != ST_DONE)) begin
            state_d = ST_IDLE;
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            vec_count_q <= '0;
            err_count_q <= '0;
            coverage_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            vec_count_q <= vec_count_d;
            err_count_q <= err_count_d;
            coverage_q  <= coverage_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign vec_count = vec_count_q;
    assign err_count = err_count_q;
    assign coverage  = coverage_q;

`ifdef GATE_CHK_FIRST_FAIL_EN
    logic       fail_valid_q, fail_valid_d;
    logic [4:0] fail_vec_q, fail_vec_d;

    always_comb begin
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        if (run_start) begin
            fail_valid_d = 1'b0;
            fail_vec_d   = '0;
        end else if (accept && mismatch && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = {ab, obs_y};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
        end else begin
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;
`endif

endmodule
